instr_issue_encoder: RTL and testbench

//  Producer end of the 8-bit instruction interface consumed by the instruction decoder.

---
 rtl/instr_issue_encoder_pkg.sv | 31 +++
 rtl/instr_issue_encoder_if.sv | 26 ++
 rtl/instr_issue_encoder_fifo.sv | 53 +++++
 rtl/instr_issue_encoder.sv | 129 ++++++++++++
 tb/tb_instr_issue_encoder.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_issue_encoder_pkg.sv
// Shared definitions for the instruction issue encoder: opcode values, halt word,
// FSM state encoding and the request-packing helpers.
package instr_enc_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_MOD = 3'b100;
   localparam logic [2:0] OP_CMP = 3'b101;

   localparam logic [7:0] HALT_WORD = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   function automatic logic [7:0] encode_word(input logic [2:0] opcode,
                                              input logic       reg_sel,
                                              input logic [3:0] operand);
      return {opcode, reg_sel, operand};
   endfunction

   // Opcodes 110/111 are undefined; 8'hFF is reserved as the halt marker.
   function automatic logic is_illegal(input logic [7:0] word);
      return (word[7:6] == 2'b11) && (word != HALT_WORD);
   endfunction

endpackage

// File: rtl/instr_issue_encoder_if.sv
// Field-level request channel (valid/ready) into the instruction issue encoder.
interface instr_issue_encoder_if;

   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_opcode;
   logic       in_reg_sel;
   logic [3:0] in_operand;

   modport master (
      output in_valid,
      output in_opcode,
      output in_reg_sel,
      output in_operand,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_opcode,
      input  in_reg_sel,
      input  in_operand,
      output in_ready
   );

endinterface

// File: rtl/instr_issue_encoder_fifo.sv
// Synchronous byte FIFO for packed instructions; reset flushes it via the pointers.
module instr_issue_fifo #(
   parameter  int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count
);

   logic [7:0]        mem_r [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [ADDR_W:0]   count_r;
   logic              push_ok;
   logic              pop_ok;

   assign full   = (count_r == (ADDR_W+1)'(DEPTH));
   assign empty  = (count_r == (ADDR_W+1)'(0));
   assign count  = count_r;
   assign rdata  = mem_r[rd_ptr_r];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r <= ADDR_W'(0);
         rd_ptr_r <= ADDR_W'(0);
         count_r  <= (ADDR_W+1)'(0);
      end else begin
         if (push_ok) wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
         if (pop_ok)  rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_r <= count_r + (ADDR_W+1)'(1);
            2'b01:   count_r <= count_r - (ADDR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array write port.
   always_ff @(posedge clock) begin
      if (push_ok) mem_r[wr_ptr_r] <= wdata;
   end

endmodule

// File: rtl/instr_issue_encoder.sv
// Instruction issue encoder: packs requests, buffers them and issues bytes under run/step/halt.
// Optional build macro INSTR_ENC_ILLEGAL_TRAP_EN drops undefined-opcode requests and counts them.
module instr_issue_encoder
   import instr_enc_pkg::*;
#(
   parameter  int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset,
   instr_issue_encoder_if.slave req,
   input  logic                 run,
   input  logic                 step,
   output logic [7:0]           instr_out,
   output logic                 instr_ena,
   output logic                 busy,
   output logic [ADDR_W:0]      count,
   output logic [7:0]           illegal_cnt
);

   state_t      state_r;
   state_t      state_nxt;
   logic [7:0]  word_s;
   logic [7:0]  head_s;
   logic        accept_s;
   logic        push_s;
   logic        pop_s;
   logic        full_s;
   logic        empty_s;
   logic [7:0]  instr_out_r;
   logic        instr_ena_r;

   assign word_s       = encode_word(req.in_opcode, req.in_reg_sel, req.in_operand);
   assign req.in_ready = !full_s;
   assign accept_s     = req.in_valid && !full_s;

`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
   logic       illegal_s;
   logic [7:0] illegal_cnt_r;

   assign illegal_s   = is_illegal(word_s);
   assign push_s      = accept_s && !illegal_s;
   assign illegal_cnt = illegal_cnt_r;

   // Saturating count of accepted-but-dropped requests.
   always_ff @(posedge clock) begin
      if (reset) begin
         illegal_cnt_r <= 8'h00;
      end else if (accept_s && illegal_s && (illegal_cnt_r != 8'hFF)) begin
         illegal_cnt_r <= illegal_cnt_r + 8'h01;
      end
   end
`else
   assign push_s      = accept_s;
   assign illegal_cnt = 8'h00;
`endif

   instr_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (word_s),
      .rdata (head_s),
      .full  (full_s),
      .empty (empty_s),
      .count (count)
   );

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_nxt;
   end

   // Next-state and pop decision; entering RUN or leaving it never pops in that cycle.
   always_comb begin
      state_nxt = state_r;
      pop_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (run) begin
               state_nxt = ST_RUN;
            end else if (step && !empty_s) begin
               pop_s = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!run) begin
               state_nxt = ST_IDLE;
            end else if (!empty_s) begin
               pop_s = 1'b1;
               if (head_s == HALT_WORD) state_nxt = ST_HALT;
               else                     state_nxt = ST_RUN;
            end else begin
               state_nxt = ST_RUN;
            end
         end
         ST_HALT: begin
            if (!run) state_nxt = ST_IDLE;
            else      state_nxt = ST_HALT;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Registered issue port; byte is forced to zero whenever the strobe is low.
   always_ff @(posedge clock) begin
      if (reset) begin
         instr_out_r <= 8'h00;
         instr_ena_r <= 1'b0;
      end else if (pop_s) begin
         instr_out_r <= head_s;
         instr_ena_r <= 1'b1;
      end else begin
         instr_out_r <= 8'h00;
         instr_ena_r <= 1'b0;
      end
   end

   assign instr_out = instr_out_r;
   assign instr_ena = instr_ena_r;
   assign busy      = !empty_s || instr_ena_r;

endmodule

// File: tb/tb_instr_issue_encoder.sv
// Directed, table-driven bench for instr_issue_encoder (honours INSTR_ENC_ILLEGAL_TRAP_EN).
module tb_instr_issue_encoder;
   import instr_enc_pkg::*;

   typedef struct {
      logic [2:0] op;
      logic       rs;
      logic [3:0] imm;
      logic [7:0] exp;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       run   = 1'b0;
   logic       step  = 1'b0;
   logic [7:0] instr_out;
   logic       instr_ena;
   logic       busy;
   logic [3:0] count;
   logic [7:0] illegal_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t tbl [6];
   vec_t seq [9];

   instr_issue_encoder_if bus ();

   instr_issue_encoder #(.DEPTH(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (bus.slave),
      .run         (run),
      .step        (step),
      .instr_out   (instr_out),
      .instr_ena   (instr_ena),
      .busy        (busy),
      .count       (count),
      .illegal_cnt (illegal_cnt)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_req(input logic [2:0] op, input logic rs, input logic [3:0] imm);
      bus.in_valid   = 1'b1;
      bus.in_opcode  = op;
      bus.in_reg_sel = rs;
      bus.in_operand = imm;
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      step  = 1'b0;
      run   = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int   k;
      int   first;
      int   last;
      int   strobes;
      logic acc;
      logic found;
      logic [7:0] seen;

      tbl[0] = '{3'b000, 1'b1, 4'h3, 8'h13};
      tbl[1] = '{3'b001, 1'b0, 4'hA, 8'h2A};
      tbl[2] = '{3'b010, 1'b1, 4'hF, 8'h5F};
      tbl[3] = '{3'b011, 1'b0, 4'h0, 8'h60};
      tbl[4] = '{3'b100, 1'b1, 4'h5, 8'h95};
      tbl[5] = '{3'b101, 1'b0, 4'h7, 8'hA7};

      seq[0] = '{3'd0, 1'b0, 4'd1, 8'h01};
      seq[1] = '{3'd1, 1'b1, 4'd2, 8'h32};
      seq[2] = '{3'd2, 1'b0, 4'd3, 8'h43};
      seq[3] = '{3'd3, 1'b1, 4'd4, 8'h74};
      seq[4] = '{3'd4, 1'b0, 4'd5, 8'h85};
      seq[5] = '{3'd5, 1'b1, 4'd6, 8'hB6};
      seq[6] = '{3'd0, 1'b0, 4'd7, 8'h07};
      seq[7] = '{3'd1, 1'b1, 4'd8, 8'h38};
      seq[8] = '{3'd2, 1'b0, 4'd9, 8'h49};

      bus.in_valid   = 1'b0;
      bus.in_opcode  = 3'b000;
      bus.in_reg_sel = 1'b0;
      bus.in_operand = 4'h0;

      // Reset state
      do_reset();
      check("rst_out",     32'(instr_out),   32'h00);
      check("rst_ena",     32'(instr_ena),   32'h0);
      check("rst_count",   32'(count),       32'h0);
      check("rst_illegal", 32'(illegal_cnt), 32'h00);
      check("rst_ready",   32'(bus.in_ready), 32'h1);
      check("rst_busy",    32'(busy),        32'h0);

      // Table: single request while running, one-cycle strobe then idle
      run = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         drive_req(tbl[i].op, tbl[i].rs, tbl[i].imm);
         tick();
         bus.in_valid = 1'b0;
         check("tbl_latency", 32'(instr_ena), 32'h0);
         tick();
         check("tbl_ena", 32'(instr_ena), 32'h1);
         check("tbl_out", 32'(instr_out), 32'(tbl[i].exp));
         tick();
         check("tbl_ena_off", 32'(instr_ena), 32'h0);
         check("tbl_out_off", 32'(instr_out), 32'h00);
      end

      // Fill to full with run low, then drain back-to-back including the held 9th
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive_req(seq[i].op, seq[i].rs, seq[i].imm);
         tick();
      end
      drive_req(seq[8].op, seq[8].rs, seq[8].imm);
      check("full_count", 32'(count),        32'd8);
      check("full_ready", 32'(bus.in_ready), 32'h0);
      tick();
      check("full_hold_count", 32'(count), 32'd8);
      check("full_no_issue",   32'(instr_ena), 32'h0);
      run   = 1'b1;
      k     = 0;
      first = -1;
      last  = -1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clock);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clock);
         #1;
         if (acc) bus.in_valid = 1'b0;
         if (instr_ena) begin
            if (k < 9) check("drain_order", 32'(instr_out), 32'(seq[k].exp));
            if (first < 0) first = cyc;
            last = cyc;
            k++;
         end
      end
      check("drain_total",   32'(k),            32'd9);
      check("drain_b2b",     32'(last - first), 32'd8);
      check("drain_empty",   32'(count),        32'd0);
      run = 1'b0;

      // Step mode: one pulse issues exactly one entry
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive_req(tbl[i].op, tbl[i].rs, tbl[i].imm);
         tick();
      end
      bus.in_valid = 1'b0;
      check("step_pre_count", 32'(count), 32'd3);
      check("step_pre_busy",  32'(busy),  32'h1);
      step = 1'b1;
      tick();
      step = 1'b0;
      check("step_ena",   32'(instr_ena), 32'h1);
      check("step_out",   32'(instr_out), 32'(tbl[0].exp));
      check("step_count", 32'(count),     32'd2);
      strobes = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (instr_ena) strobes++;
      end
      check("step_single",     32'(strobes), 32'd0);
      check("step_post_count", 32'(count),   32'd2);

      // Step on empty FIFO is ignored and not remembered
      do_reset();
      step = 1'b1;
      tick();
      step = 1'b0;
      check("step_empty_ena", 32'(instr_ena), 32'h0);
      drive_req(tbl[1].op, tbl[1].rs, tbl[1].imm);
      tick();
      bus.in_valid = 1'b0;
      strobes = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (instr_ena) strobes++;
      end
      check("step_not_queued", 32'(strobes), 32'd0);
      check("step_held_count", 32'(count),   32'd1);

      // HALT word stops issue; run toggle resumes
      do_reset();
      run = 1'b1;
      tick();
      drive_req(OP_SUB, 1'b0, 4'h1);
      tick();
      drive_req(3'b111, 1'b1, 4'hF);
      tick();
      check("halt_sub_ena", 32'(instr_ena), 32'h1);
      check("halt_sub_out", 32'(instr_out), 32'h21);
      drive_req(OP_MUL, 1'b1, 4'h2);
      tick();
      bus.in_valid = 1'b0;
      check("halt_ff_ena", 32'(instr_ena), 32'h1);
      check("halt_ff_out", 32'(instr_out), 32'hFF);
      tick();
      check("halt_stop_ena",   32'(instr_ena), 32'h0);
      check("halt_stop_count", 32'(count),     32'd1);
      tick();
      check("halt_hold_ena", 32'(instr_ena), 32'h0);
      run = 1'b0;
      tick();
      run   = 1'b1;
      found = 1'b0;
      seen  = 8'h00;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (instr_ena && !found) begin
            found = 1'b1;
            seen  = instr_out;
         end
      end
      check("resume_found", 32'(found), 32'h1);
      check("resume_out",   32'(seen),  32'h52);
      check("resume_count", 32'(count), 32'd0);

      // Undefined opcode 110
      do_reset();
      run = 1'b1;
      tick();
      drive_req(3'b110, 1'b0, 4'h5);
      check("illegal_ready", 32'(bus.in_ready), 32'h1);
      tick();
      bus.in_valid = 1'b0;
      strobes = 0;
      seen    = 8'h00;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (instr_ena) begin
            strobes++;
            seen = instr_out;
         end
      end
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
      check("illegal_dropped", 32'(strobes),     32'd0);
      check("illegal_cnt",     32'(illegal_cnt), 32'd1);
      check("illegal_count",   32'(count),       32'd0);
`else
      check("illegal_issued",  32'(strobes),     32'd1);
      check("illegal_out",     32'(seen),        32'hC5);
      check("illegal_cnt",     32'(illegal_cnt), 32'd0);
`endif

      // Reset in the middle of RUN flushes everything
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive_req(tbl[i].op, tbl[i].rs, tbl[i].imm);
         tick();
      end
      bus.in_valid = 1'b0;
      run   = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         tick();
         if (instr_ena) found = 1'b1;
      end
      check("midrst_started", 32'(found), 32'h1);
      reset = 1'b1;
      tick();
      check("midrst_ena",   32'(instr_ena),     32'h0);
      check("midrst_out",   32'(instr_out),     32'h00);
      check("midrst_count", 32'(count),         32'd0);
      check("midrst_ready", 32'(bus.in_ready),  32'h1);
      check("midrst_busy",  32'(busy),          32'h0);
      check("midrst_state", 32'(dut.state_r),   32'(ST_IDLE));
      reset = 1'b0;
      run   = 1'b0;
      tick();
      check("midrst_after_ena",   32'(instr_ena), 32'h0);
      check("midrst_after_count", 32'(count),     32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
